// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch-to-decode queue: datapath width, the
// instruction word shown when the queue is empty, and the occupancy width.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    // An empty queue presents an all-zero word to decode.
    localparam logic [XLEN-1:0] NOP_INSTR = '0;

    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port, no reset on the array itself.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] entries [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order buffer between IF and ID: freezes IF when full and squashes all
// entries on a taken branch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_PC,
    input  logic [WIDTH-1:0]             in_Instruction,
    input  logic                         flush,
    input  logic                         dec_freeze,
    output logic                         freeze_if,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_PC,
    output logic [WIDTH-1:0]             out_Instruction,
    output logic [countWidth(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = countWidth(DEPTH);

    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic [CW-1:0]      occupancy;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] headData;

    assign full  = (occupancy == CW'(DEPTH));
    assign empty = (occupancy == '0);

    // Flush wins over both ends so the branch shadow never enters the queue.
    assign push = in_valid & ~full & ~flush;
    assign pop  = ~empty & ~dec_freeze & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) mem (
        .clk   (clk),
        .we    (push),
        .waddr (wrPtr),
        .wdata ({in_PC, in_Instruction}),
        .raddr (rdPtr),
        .rdata (headData)
    );

    // Freeze comes from registered occupancy only, so a pop while full costs
    // one bubble instead of a dec_freeze-to-IF combinational path.
    assign freeze_if       = full;
    assign out_valid       = ~empty;
    assign count           = occupancy;
    assign out_PC          = empty ? '0 : headData[2*WIDTH-1:WIDTH];
    assign out_Instruction = empty ? WIDTH'(NOP_INSTR) : headData[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed scoreboard bench for fetch_queue against a
// queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] ins;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inValid = 1'b0;
    logic [WIDTH-1:0] inPc = '0;
    logic [WIDTH-1:0] inIns = '0;
    logic             flush = 1'b0;
    logic             decFreeze = 1'b0;
    logic             freezeIf;
    logic             outValid;
    logic [WIDTH-1:0] outPc;
    logic [WIDTH-1:0] outIns;
    logic [2:0]       count;

    int checks = 0;
    int errors = 0;
    entry_t modelQ[$];

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (inValid),
        .in_PC           (inPc),
        .in_Instruction  (inIns),
        .flush           (flush),
        .dec_freeze      (decFreeze),
        .freeze_if       (freezeIf),
        .out_valid       (outValid),
        .out_PC          (outPc),
        .out_Instruction (outIns),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain FIFO of accepted pairs, updated at each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            modelQ.delete();
        end else if (flush) begin
            modelQ.delete();
        end else begin
            automatic bit canPush = inValid && (modelQ.size() < DEPTH);
            automatic bit doPop   = (modelQ.size() > 0) && !decFreeze;
            automatic entry_t e;
            e.pc  = inPc;
            e.ins = inIns;
            if (doPop) void'(modelQ.pop_front());
            if (canPush) modelQ.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the model head mid-cycle.
    always @(negedge clk) begin
        automatic int n = modelQ.size();
        checkOutput("count", 64'(count), 64'(n));
        checkOutput("freeze_if", 64'(freezeIf), 64'(n == DEPTH));
        checkOutput("out_valid", 64'(outValid), 64'(n != 0));
        if (n != 0) begin
            checkOutput("out_PC", 64'(outPc), 64'(modelQ[0].pc));
            checkOutput("out_Instruction", 64'(outIns), 64'(modelQ[0].ins));
        end else begin
            checkOutput("out_PC_zero", 64'(outPc), 64'h0);
            checkOutput("out_Instruction_zero", 64'(outIns), 64'h0);
        end
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins,
                                 input logic fl, input logic fr);
        inValid   = v;
        inPc      = pc;
        inIns     = ins;
        flush     = fl;
        decFreeze = fr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles with a pair on the input.
        inValid = 1'b1;
        inPc    = 32'd4;
        inIns   = 32'hE3A01005;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_count", 64'(count), 64'h0);
        checkOutput("reset_out_valid", 64'(outValid), 64'h0);
        rst = 1'b1;

        // First push, then fill while decode is stalled; fifth pair ignored.
        applyStimulus(1, 32'd4, 32'hE3A01005, 0, 1);
        checkOutput("first_push_pc", 64'(outPc), 64'd4);
        for (int i = 2; i <= 4; i++) applyStimulus(1, 32'(4 * i), 32'hE000_0000 + 32'(i), 0, 1);
        checkOutput("full_freeze", 64'(freezeIf), 64'h1);
        applyStimulus(1, 32'd20, 32'hE000_0005, 0, 1);
        checkOutput("full_ignored_count", 64'(count), 64'd4);

        // Drain in order.
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, '0, 0, 0);
        checkOutput("drained_count", 64'(count), 64'h0);

        // Streaming across the pointer wrap.
        for (int i = 1; i <= 10; i++) applyStimulus(1, 32'(4 * i), 32'hE1A0_0000 + 32'(i), 0, 0);
        applyStimulus(0, '0, '0, 0, 0);

        // Flush with three queued and a pair incoming.
        for (int i = 1; i <= 3; i++) applyStimulus(1, 32'(4 * i + 12), 32'hE2800000 + 32'(i), 0, 1);
        applyStimulus(1, 32'd28, 32'hE2800004, 1, 1);
        checkOutput("flush_count", 64'(count), 64'h0);
        applyStimulus(1, 32'h100, 32'hEA000000, 0, 1);
        checkOutput("post_flush_head", 64'(outPc), 64'h100);
        applyStimulus(0, '0, '0, 0, 0);

        // Flush while full and frozen.
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h200 + 32'(4 * i), 32'(i), 0, 1);
        checkOutput("prefull_freeze", 64'(freezeIf), 64'h1);
        applyStimulus(1, 32'h300, 32'h0, 1, 1);
        checkOutput("flush_full_freeze", 64'(freezeIf), 64'h0);

        // Randomised traffic with a mid-operation asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #3;
                rst = 1'b0;
                #1;
                checkOutput("async_reset_valid", 64'(outValid), 64'h0);
                checkOutput("async_reset_count", 64'(count), 64'h0);
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
        end
        applyStimulus(0, '0, '0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
